// File: rtl/dispatcher_pkg.sv
// Shared constants and types for the dispatch stage.
//   OPENUM_TYPE / ROB_ID_TYPE / DATA_TYPE / ADDR_TYPE / REG_ID_TYPE : field widths
//   OPENUM_NOP : opcode driven on the issue bus when nothing is dispatched
//   ZERO_ROB   : ROB tag meaning "operand value is ready"
package dispatcher_pkg;

  localparam int unsigned OPENUM_TYPE = 6;
  localparam int unsigned ROB_ID_TYPE = 4;
  localparam int unsigned DATA_TYPE   = 32;
  localparam int unsigned ADDR_TYPE   = 32;
  localparam int unsigned REG_ID_TYPE = 5;

  typedef logic [OPENUM_TYPE-1:0] openum_t;
  typedef logic [ROB_ID_TYPE-1:0] rob_id_t;
  typedef logic [DATA_TYPE-1:0]   data_t;
  typedef logic [ADDR_TYPE-1:0]   addr_t;
  typedef logic [REG_ID_TYPE-1:0] reg_id_t;

  localparam openum_t OPENUM_NOP = '0;
  localparam rob_id_t ZERO_ROB   = '0;

endpackage

// File: rtl/dispatcher_operand.sv
// Resolves one source operand into a (Q, V) pair for the issue bus.
//   rs                    : source register index (x0 reads as ready zero)
//   q_reg / v_reg         : tag and value from the register file
//   fwd_valid/rd/rob      : rename issued by the previous dispatch (not yet in the regfile)
//   arith_* / ls_*        : CDB broadcasts, only consulted with DISPATCHER_CDB_BYPASS_EN
//   q / v                 : resolved tag and value
// Optional feature macro: DISPATCHER_CDB_BYPASS_EN.
module dispatcher_operand
  import dispatcher_pkg::*;
(
  input  reg_id_t rs,
  input  rob_id_t q_reg,
  input  data_t   v_reg,
  input  logic    fwd_valid,
  input  reg_id_t fwd_rd,
  input  rob_id_t fwd_rob,
  input  logic    arith_valid,
  input  rob_id_t arith_rob,
  input  data_t   arith_result,
  input  logic    ls_valid,
  input  rob_id_t ls_rob,
  input  data_t   ls_result,
  output rob_id_t q,
  output data_t   v
);

`ifndef DISPATCHER_CDB_BYPASS_EN
  // Consumers snoop the CDB themselves in this build.
  logic unused_cdb;
  assign unused_cdb = ^{arith_valid, arith_rob, arith_result, ls_valid, ls_rob, ls_result};
`endif

  always_comb begin
    q = q_reg;
    v = v_reg;
    if (rs == '0) begin
      q = ZERO_ROB;
      v = '0;
    end else begin
      // The regfile has not yet seen the rename from the previous dispatch.
      if (fwd_valid && fwd_rd == rs) begin
        q = fwd_rob;
      end
`ifdef DISPATCHER_CDB_BYPASS_EN
      if (q != ZERO_ROB) begin
        if (arith_valid && arith_rob == q) begin
          q = ZERO_ROB;
          v = arith_result;
        end else if (ls_valid && ls_rob == q) begin
          q = ZERO_ROB;
          v = ls_result;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/dispatcher.sv
// Dispatch stage: accepts decoded instructions, resolves operands, renames rd,
// and issues to the ROB plus either the reservation station or the load/store buffer.
//   clk, rst (sync, active high), rdy (global stall: low holds all state)
//   decoder handshake : valid_from_decoder / ready_to_decoder (combinational)
//   regfile read      : rs1/rs2_to_reg out, Q1/Q2/V1/V2_from_reg in
//   rename            : rename_enable_to_reg, rd_to_reg, rob_id_to_reg (registered)
//   rob               : rob_id_from_rob, full_from_rob, enable_to_rob, clear_from_rob
//   rs / lsb          : full_from_rs/lsb, enable_to_rs/lsb
//   issue bus         : *_to_issue (registered, one-cycle latency)
//   cdb               : Arith and LS broadcasts (used only with DISPATCHER_CDB_BYPASS_EN)
module dispatcher
  import dispatcher_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  input  logic    valid_from_decoder,
  output logic    ready_to_decoder,
  input  openum_t openum_from_decoder,
  input  reg_id_t rd_from_decoder,
  input  reg_id_t rs1_from_decoder,
  input  reg_id_t rs2_from_decoder,
  input  data_t   imm_from_decoder,
  input  addr_t   pc_from_decoder,
  input  logic    is_ls_from_decoder,
  output reg_id_t rs1_to_reg,
  output reg_id_t rs2_to_reg,
  input  rob_id_t Q1_from_reg,
  input  rob_id_t Q2_from_reg,
  input  data_t   V1_from_reg,
  input  data_t   V2_from_reg,
  output logic    rename_enable_to_reg,
  output reg_id_t rd_to_reg,
  output rob_id_t rob_id_to_reg,
  input  rob_id_t rob_id_from_rob,
  input  logic    full_from_rob,
  output logic    enable_to_rob,
  input  logic    full_from_rs,
  input  logic    full_from_lsb,
  output logic    enable_to_rs,
  output logic    enable_to_lsb,
  output openum_t openum_to_issue,
  output rob_id_t Q1_to_issue,
  output rob_id_t Q2_to_issue,
  output data_t   V1_to_issue,
  output data_t   V2_to_issue,
  output addr_t   pc_to_issue,
  output data_t   imm_to_issue,
  output rob_id_t rob_id_to_issue,
  output reg_id_t rd_to_issue,
  input  logic    clear_from_rob,
  input  logic    valid_from_Arith_unit_cdb,
  input  rob_id_t rob_id_from_Arith_unit_cdb,
  input  data_t   result_from_Arith_unit_cdb,
  input  logic    valid_from_LS_unit_cdb,
  input  rob_id_t rob_id_from_LS_unit_cdb,
  input  data_t   result_from_LS_unit_cdb
);

  logic    accept;
  rob_id_t q1, q2;
  data_t   v1, v2;

  assign rs1_to_reg = rs1_from_decoder;
  assign rs2_to_reg = rs2_from_decoder;

  assign ready_to_decoder = !full_from_rob &&
                            !(is_ls_from_decoder ? full_from_lsb : full_from_rs) &&
                            !clear_from_rob;
  assign accept = valid_from_decoder && ready_to_decoder && rdy;

  dispatcher_operand u_op1 (
    .rs           (rs1_from_decoder),
    .q_reg        (Q1_from_reg),
    .v_reg        (V1_from_reg),
    .fwd_valid    (rename_enable_to_reg),
    .fwd_rd       (rd_to_reg),
    .fwd_rob      (rob_id_to_reg),
    .arith_valid  (valid_from_Arith_unit_cdb),
    .arith_rob    (rob_id_from_Arith_unit_cdb),
    .arith_result (result_from_Arith_unit_cdb),
    .ls_valid     (valid_from_LS_unit_cdb),
    .ls_rob       (rob_id_from_LS_unit_cdb),
    .ls_result    (result_from_LS_unit_cdb),
    .q            (q1),
    .v            (v1)
  );

  dispatcher_operand u_op2 (
    .rs           (rs2_from_decoder),
    .q_reg        (Q2_from_reg),
    .v_reg        (V2_from_reg),
    .fwd_valid    (rename_enable_to_reg),
    .fwd_rd       (rd_to_reg),
    .fwd_rob      (rob_id_to_reg),
    .arith_valid  (valid_from_Arith_unit_cdb),
    .arith_rob    (rob_id_from_Arith_unit_cdb),
    .arith_result (result_from_Arith_unit_cdb),
    .ls_valid     (valid_from_LS_unit_cdb),
    .ls_rob       (rob_id_from_LS_unit_cdb),
    .ls_result    (result_from_LS_unit_cdb),
    .q            (q2),
    .v            (v2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_to_rob        <= 1'b0;
      enable_to_rs         <= 1'b0;
      enable_to_lsb        <= 1'b0;
      rename_enable_to_reg <= 1'b0;
      rd_to_reg            <= '0;
      rob_id_to_reg        <= ZERO_ROB;
      openum_to_issue      <= OPENUM_NOP;
      Q1_to_issue          <= ZERO_ROB;
      Q2_to_issue          <= ZERO_ROB;
      V1_to_issue          <= '0;
      V2_to_issue          <= '0;
      pc_to_issue          <= '0;
      imm_to_issue         <= '0;
      rob_id_to_issue      <= ZERO_ROB;
      rd_to_issue          <= '0;
    end else if (rdy) begin
      // Enables are single-cycle pulses; a flush lands here too since accept is low.
      enable_to_rob        <= 1'b0;
      enable_to_rs         <= 1'b0;
      enable_to_lsb        <= 1'b0;
      rename_enable_to_reg <= 1'b0;
      openum_to_issue      <= OPENUM_NOP;
      if (accept) begin
        enable_to_rob        <= 1'b1;
        enable_to_rs         <= !is_ls_from_decoder;
        enable_to_lsb        <= is_ls_from_decoder;
        rename_enable_to_reg <= (rd_from_decoder != '0);
        rd_to_reg            <= rd_from_decoder;
        rob_id_to_reg        <= rob_id_from_rob;
        openum_to_issue      <= openum_from_decoder;
        Q1_to_issue          <= q1;
        Q2_to_issue          <= q2;
        V1_to_issue          <= v1;
        V2_to_issue          <= v2;
        pc_to_issue          <= pc_from_decoder;
        imm_to_issue         <= imm_from_decoder;
        rob_id_to_issue      <= rob_id_from_rob;
        rd_to_issue          <= rd_from_decoder;
      end
    end
  end

endmodule

// File: tb/tb_dispatcher.sv
module tb_dispatcher;
  import dispatcher_pkg::*;

  logic    clk = 1'b0;
  logic    rst, rdy, valid_from_decoder, ready_to_decoder;
  openum_t openum_from_decoder;
  reg_id_t rd_from_decoder, rs1_from_decoder, rs2_from_decoder, rs1_to_reg, rs2_to_reg;
  data_t   imm_from_decoder, V1_from_reg, V2_from_reg;
  addr_t   pc_from_decoder;
  logic    is_ls_from_decoder;
  rob_id_t Q1_from_reg, Q2_from_reg;
  logic    rename_enable_to_reg;
  reg_id_t rd_to_reg;
  rob_id_t rob_id_to_reg, rob_id_from_rob;
  logic    full_from_rob, enable_to_rob, full_from_rs, full_from_lsb;
  logic    enable_to_rs, enable_to_lsb;
  openum_t openum_to_issue;
  rob_id_t Q1_to_issue, Q2_to_issue, rob_id_to_issue;
  data_t   V1_to_issue, V2_to_issue, imm_to_issue;
  addr_t   pc_to_issue;
  reg_id_t rd_to_issue;
  logic    clear_from_rob;
  logic    av, lv;
  rob_id_t aid, lid;
  data_t   ares, lres;

  dispatcher dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .valid_from_decoder(valid_from_decoder), .ready_to_decoder(ready_to_decoder),
    .openum_from_decoder(openum_from_decoder), .rd_from_decoder(rd_from_decoder),
    .rs1_from_decoder(rs1_from_decoder), .rs2_from_decoder(rs2_from_decoder),
    .imm_from_decoder(imm_from_decoder), .pc_from_decoder(pc_from_decoder),
    .is_ls_from_decoder(is_ls_from_decoder),
    .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
    .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
    .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
    .rename_enable_to_reg(rename_enable_to_reg), .rd_to_reg(rd_to_reg),
    .rob_id_to_reg(rob_id_to_reg), .rob_id_from_rob(rob_id_from_rob),
    .full_from_rob(full_from_rob), .enable_to_rob(enable_to_rob),
    .full_from_rs(full_from_rs), .full_from_lsb(full_from_lsb),
    .enable_to_rs(enable_to_rs), .enable_to_lsb(enable_to_lsb),
    .openum_to_issue(openum_to_issue), .Q1_to_issue(Q1_to_issue),
    .Q2_to_issue(Q2_to_issue), .V1_to_issue(V1_to_issue), .V2_to_issue(V2_to_issue),
    .pc_to_issue(pc_to_issue), .imm_to_issue(imm_to_issue),
    .rob_id_to_issue(rob_id_to_issue), .rd_to_issue(rd_to_issue),
    .clear_from_rob(clear_from_rob),
    .valid_from_Arith_unit_cdb(av), .rob_id_from_Arith_unit_cdb(aid),
    .result_from_Arith_unit_cdb(ares),
    .valid_from_LS_unit_cdb(lv), .rob_id_from_LS_unit_cdb(lid),
    .result_from_LS_unit_cdb(lres)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [153:0] bus;  // issue bus plus the three enables
    logic         ren;
    reg_id_t      rd;
    rob_id_t      rob;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Most recent dispatch seen at a non-stalled edge: its rename is still in flight.
  logic    prev_ren = 1'b0;
  reg_id_t prev_rd;
  rob_id_t prev_rob;
  logic    last_rst = 1'b1, last_rdy = 1'b0;

  task automatic check(input string name, input logic [163:0] act, input logic [163:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic model_ready();
    return !full_from_rob && !(is_ls_from_decoder ? full_from_lsb : full_from_rs)
           && !clear_from_rob;
  endfunction

  // What operand n should look like, from the architectural rules.
  function automatic void operand(input reg_id_t rs, input rob_id_t qr, input data_t vr,
                                  output rob_id_t q, output data_t v);
    if (rs == 0) begin
      q = 0;
      v = 0;
      return;
    end
    q = (prev_ren && prev_rd == rs) ? prev_rob : qr;
    v = vr;
`ifdef DISPATCHER_CDB_BYPASS_EN
    if (q != 0 && av && aid == q) begin
      v = ares;
      q = 0;
    end else if (q != 0 && lv && lid == q) begin
      v = lres;
      q = 0;
    end
`endif
  endfunction

  // Reference model: decides acceptance at each edge and queues the expected issue.
  always @(posedge clk) begin
    exp_t    e;
    rob_id_t q1, q2;
    data_t   v1, v2;
    last_rst = rst;
    last_rdy = rdy;
    if (rst) begin
      prev_ren = 1'b0;
    end else if (rdy) begin
      if (valid_from_decoder && model_ready()) begin
        operand(rs1_from_decoder, Q1_from_reg, V1_from_reg, q1, v1);
        operand(rs2_from_decoder, Q2_from_reg, V2_from_reg, q2, v2);
        e.bus = {openum_from_decoder, q1, q2, v1, v2, pc_from_decoder, imm_from_decoder,
                 rob_id_from_rob, rd_from_decoder, 1'b1, !is_ls_from_decoder,
                 is_ls_from_decoder};
        e.ren = rd_from_decoder != 0;
        e.rd  = rd_from_decoder;
        e.rob = rob_id_from_rob;
        exp_q.push_back(e);
        prev_ren = e.ren;
        prev_rd  = e.rd;
        prev_rob = e.rob;
      end else begin
        prev_ren = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs shortly after each edge.
  logic [163:0] snap = '0;
  always @(posedge clk) begin
    logic [163:0] cur;
    exp_t         e;
    #1;
    cur = {openum_to_issue, Q1_to_issue, Q2_to_issue, V1_to_issue, V2_to_issue,
           pc_to_issue, imm_to_issue, rob_id_to_issue, rd_to_issue, enable_to_rob,
           enable_to_rs, enable_to_lsb, rename_enable_to_reg, rd_to_reg, rob_id_to_reg};
    if (last_rst) begin
      check("reset_state", cur, {OPENUM_NOP, 158'd0});
      exp_q.delete();
    end else if (!last_rdy) begin
      check("stall_hold", cur, snap);
    end else if (enable_to_rob) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 164'(enable_to_rob), 164'd0);
      end else begin
        e = exp_q.pop_front();
        check("issue_bus", 164'(cur[163:10]), 164'(e.bus));
        if (e.ren)
          check("rename", 164'({rename_enable_to_reg, rd_to_reg, rob_id_to_reg}),
                164'({1'b1, e.rd, e.rob}));
        else
          check("no_rename_x0", 164'(rename_enable_to_reg), 164'd0);
      end
    end else begin
      check("idle_outputs", 164'({openum_to_issue, enable_to_rs, enable_to_lsb,
                                  rename_enable_to_reg}), 164'({OPENUM_NOP, 3'b000}));
      if (exp_q.size() != 0) begin
        check("lost_issue", 164'(exp_q.size()), 164'd0);
        exp_q.delete();
      end
    end
    snap = cur;
  end

  // Combinational outputs, checked between edges.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      check("ready", 164'(ready_to_decoder), 164'(model_ready()));
      check("rs_to_reg", 164'({rs1_to_reg, rs2_to_reg}),
            164'({rs1_from_decoder, rs2_from_decoder}));
    end
  end

  task automatic idle();
    rst = 0; rdy = 1; valid_from_decoder = 0; openum_from_decoder = 6'd1;
    rd_from_decoder = 0; rs1_from_decoder = 0; rs2_from_decoder = 0;
    imm_from_decoder = 0; pc_from_decoder = 0; is_ls_from_decoder = 0;
    Q1_from_reg = 0; Q2_from_reg = 0; V1_from_reg = 0; V2_from_reg = 0;
    rob_id_from_rob = 4'd1; full_from_rob = 0; full_from_rs = 0; full_from_lsb = 0;
    clear_from_rob = 0; av = 0; lv = 0; aid = 0; lid = 0; ares = 0; lres = 0;
  endtask

  task automatic instr(input openum_t op, input reg_id_t rd, input reg_id_t r1,
                       input reg_id_t r2, input rob_id_t rob, input logic ls);
    valid_from_decoder = 1; openum_from_decoder = op; rd_from_decoder = rd;
    rs1_from_decoder = r1; rs2_from_decoder = r2; rob_id_from_rob = rob;
    is_ls_from_decoder = ls; pc_from_decoder = $urandom; imm_from_decoder = $urandom;
  endtask

  task automatic randomize_inputs();
    rst = ($urandom_range(0, 199) == 0);
    rdy = ($urandom_range(0, 9) != 0);
    valid_from_decoder = ($urandom_range(0, 9) < 7);
    openum_from_decoder = 6'($urandom_range(1, 63));
    rd_from_decoder = 5'($urandom_range(0, 3));
    rs1_from_decoder = 5'($urandom_range(0, 3));
    rs2_from_decoder = 5'($urandom_range(0, 3));
    imm_from_decoder = $urandom; pc_from_decoder = $urandom;
    is_ls_from_decoder = $urandom_range(0, 1) == 1;
    Q1_from_reg = 4'($urandom_range(0, 15)); Q2_from_reg = 4'($urandom_range(0, 15));
    V1_from_reg = $urandom; V2_from_reg = $urandom;
    rob_id_from_rob = 4'($urandom_range(1, 15));
    full_from_rob = ($urandom_range(0, 9) == 0);
    full_from_rs = ($urandom_range(0, 5) == 0);
    full_from_lsb = ($urandom_range(0, 5) == 0);
    clear_from_rob = ($urandom_range(0, 19) == 0);
    av = $urandom_range(0, 1) == 1; lv = $urandom_range(0, 1) == 1;
    aid = ($urandom_range(0, 1) == 1) ? Q1_from_reg : 4'($urandom_range(0, 15));
    lid = ($urandom_range(0, 1) == 1) ? Q2_from_reg : 4'($urandom_range(0, 15));
    ares = $urandom; lres = $urandom;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) @(negedge clk);
    idle();
    @(negedge clk);
    // ADD x5 <- x1 + x2
    instr(6'd1, 5'd5, 5'd1, 5'd2, 4'd3, 1'b0);
    V1_from_reg = 5; V2_from_reg = 7;
    @(negedge clk);
    // I1 writes x4 as rob 2, I2 reads x4 the next cycle with a stale regfile tag
    instr(6'd2, 5'd4, 5'd0, 5'd0, 4'd2, 1'b0);
    @(negedge clk);
    instr(6'd3, 5'd6, 5'd4, 5'd0, 4'd5, 1'b0);
    Q1_from_reg = 0; V1_from_reg = 32'h1234;
    @(negedge clk);
    // Load blocked by a full LSB, then released
    idle();
    instr(6'd4, 5'd7, 5'd1, 5'd0, 4'd6, 1'b1);
    full_from_lsb = 1;
    repeat (2) @(negedge clk);
    full_from_lsb = 0;
    @(negedge clk);
    // Operand waiting on tag 6 while the Arith CDB broadcasts tag 6
    idle();
    instr(6'd5, 5'd8, 5'd3, 5'd0, 4'd7, 1'b0);
    Q1_from_reg = 6; V1_from_reg = 32'h55; av = 1; aid = 6; ares = 32'hAA;
    @(negedge clk);
    // Flush on an otherwise-accepting cycle
    idle();
    instr(6'd6, 5'd9, 5'd0, 5'd0, 4'd8, 1'b0);
    clear_from_rob = 1;
    @(negedge clk);
    clear_from_rob = 0;
    instr(6'd7, 5'd10, 5'd9, 5'd0, 4'd9, 1'b0);
    @(negedge clk);
    // Three-cycle stall mid-stream
    instr(6'd8, 5'd11, 5'd10, 5'd0, 4'd10, 1'b0);
    rdy = 0;
    repeat (3) @(negedge clk);
    rdy = 1;
    @(negedge clk);
    instr(6'd9, 5'd12, 5'd11, 5'd0, 4'd11, 1'b0);
    @(negedge clk);
    // Reset with an acceptance pending
    instr(6'd10, 5'd13, 5'd0, 5'd0, 4'd12, 1'b0);
    rst = 1;
    @(negedge clk);
    idle();
    @(negedge clk);
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      @(negedge clk);
    end
    idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
